// File: rtl/temp_sample_scheduler.sv
// Purpose : periodic temperature sampler; requests a sensor read on each tick, converts C->F, strobes the stats block.
// Latency : new_temp_valid rises 2 cycles after the cycle in which sensor_ack is sampled.
// Backpress: none downstream; one tick can be held pending, further ticks are dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n            single clock, async active-low reset
//   enable, clear_req     sampling enable; one-cycle stats clear request
//   sensor_req/ack/data   read handshake to the sensor interface (data: 13b signed, 1/16 degC)
//   new_temp(_valid)      8b Fahrenheit sample with one-cycle qualifier
//   stats_rst             one-cycle clear pulse to the stats block
//   busy, timeout_err, overrun, sample_count   status

module temp_sample_scheduler #(
    parameter int unsigned SAMPLE_DIV = 100000000,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned RETRIES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear_req,
    output logic        sensor_req,
    input  logic        sensor_ack,
    input  logic [12:0] sensor_data,
    output logic [7:0]  new_temp,
    output logic        new_temp_valid,
    output logic        stats_rst,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun,
    output logic [15:0] sample_count
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TMO_W = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
    localparam int ATT_W = (RETRIES > 0)    ? $clog2(RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CONV,
        S_PUSH,
        S_CLR
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic               gap_q, gap_d;
    logic               tick_pend_q, tick_pend_d;
    logic               clr_pend_q, clr_pend_d;
    logic signed [12:0] data_q, data_d;
    logic [7:0]         temp_q, temp_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               tick;
    logic               start_req;
    logic               clr_take;
    logic signed [17:0] prod_s, quot_s, fdeg_s;
    logic [7:0]         fdeg_sat;

    // Free-running divider; ticks whether or not sampling is enabled.
    always_comb begin
        tick  = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // F = C*9/5 + 32 with C in 1/16 degC  ->  data*9/80 + 32.
    // Signed division truncates toward zero, so small negatives round up to 32.
    always_comb begin
        prod_s = $signed({{5{data_q[12]}}, data_q}) * 18'sd9;
        quot_s = prod_s / 18'sd80;
        fdeg_s = quot_s + 18'sd32;
        if (fdeg_s < 18'sd0) begin
            fdeg_sat = 8'd0;
        end else if (fdeg_s > 18'sd255) begin
            fdeg_sat = 8'd255;
        end else begin
            fdeg_sat = fdeg_s[7:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        att_d          = att_q;
        gap_d          = gap_q;
        data_d         = data_q;
        temp_d         = temp_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        start_req      = 1'b0;
        clr_take       = 1'b0;
        sensor_req     = 1'b0;
        new_temp_valid = 1'b0;
        stats_rst      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A latched clear always goes ahead of a pending tick.
                if (clr_pend_q) begin
                    clr_take = 1'b1;
                    state_d  = S_CLR;
                end else if (tick_pend_q && enable) begin
                    start_req = 1'b1;
                    tmo_d     = '0;
                    att_d     = '0;
                    gap_d     = 1'b0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (gap_q) begin
                    // One idle cycle between attempts; an ack here is not honoured.
                    gap_d = 1'b0;
                end else begin
                    sensor_req = 1'b1;
                    if (sensor_ack) begin
                        data_d  = $signed(sensor_data);
                        state_d = S_CONV;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        tmo_d = '0;
                        if (att_q == ATT_W'(RETRIES)) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            att_d = att_q + ATT_W'(1);
                            gap_d = 1'b1;
                        end
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            S_CONV: begin
                temp_d  = fdeg_sat;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                new_temp_valid = 1'b1;
                cnt_d          = cnt_q + 16'd1;
                state_d        = S_IDLE;
            end
            S_CLR: begin
                stats_rst = 1'b1;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending flags: a new tick wins over consumption in the same cycle;
    // a tick held while the scheduler sits disabled in IDLE is thrown away.
    always_comb begin
        tick_pend_d = tick_pend_q;
        if (tick && enable) begin
            tick_pend_d = 1'b1;
        end else if (start_req || (state_q == S_IDLE && !enable)) begin
            tick_pend_d = 1'b0;
        end
        ovr_d      = ovr_q | (tick & enable & tick_pend_q & ~start_req);
        clr_pend_d = clear_req | (clr_pend_q & ~clr_take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tmo_q       <= '0;
            att_q       <= '0;
            gap_q       <= 1'b0;
            tick_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            data_q      <= '0;
            temp_q      <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tmo_q       <= tmo_d;
            att_q       <= att_d;
            gap_q       <= gap_d;
            tick_pend_q <= tick_pend_d;
            clr_pend_q  <= clr_pend_d;
            data_q      <= data_d;
            temp_q      <= temp_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign new_temp     = temp_q;
    assign timeout_err  = err_q;
    assign overrun      = ovr_q;
    assign sample_count = cnt_q;

endmodule
